// File: rtl/x9_isa_pkg.sv
// Shared X9 instruction-set definitions: field classes, opcodes, word prefixes
// and the program-load encoder state type.
package x9_isa_pkg;

  typedef enum logic [1:0] {
    CLS_R    = 2'b00,
    CLS_RSVD = 2'b01,
    CLS_MOVR = 2'b10,
    CLS_MOVI = 2'b11
  } inst_class_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOT  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_INC  = 5'd8;
  localparam logic [4:0] OP_DEC  = 5'd9;
  localparam logic [4:0] OP_CMP  = 5'd10;
  localparam logic [4:0] OP_MOV  = 5'd11;
  localparam logic [4:0] OP_LD   = 5'd12;
  localparam logic [4:0] OP_ST   = 5'd13;
  localparam logic [4:0] OP_RAND = 5'd14;
  localparam logic [4:0] OP_RXOR = 5'd15;

  localparam logic [1:0] MOVR_PFX = 2'b10;
  localparam logic [1:0] MOVI_PFX = 2'b11;

  localparam logic [8:0] HALT_WORD_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-beat valid/ready stream from the program loader into the encoder.
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_class;
  logic [4:0] in_op;
  logic [3:0] in_a;
  logic [2:0] in_b;
  logic [6:0] in_imm;
  logic       in_last;

  modport master (
    output in_valid, in_class, in_op, in_a, in_b, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_op, in_a, in_b, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field-to-word packer for the 9-bit X9 format; flags beats that
// have no legal encoding (reserved class or opcode above 15).
module instr_pack
  import x9_isa_pkg::*;
(
  input  logic [1:0] cls_i,
  input  logic [4:0] op_i,
  input  logic [3:0] a_i,
  input  logic [2:0] b_i,
  input  logic [6:0] imm_i,
  output logic [8:0] word_o,
  output logic       illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (inst_class_t'(cls_i))
      CLS_R: begin
        word_o    = {op_i, a_i};
        illegal_o = op_i[4];
      end
      CLS_MOVR: word_o = {MOVR_PFX, a_i, b_i};
      CLS_MOVI: word_o = {MOVI_PFX, imm_i};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program-load encoder: packs field beats into 9-bit words, writes them from
// address 0 and appends a terminator. Optional running checksum: ENC_CHECKSUM_EN.
module instr_encoder
  import x9_isa_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter logic [8:0]  HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_start,
  instr_encoder_if.slave in_if,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [8:0]     mem_wdata,
  output logic           busy,
  output logic           done,
  output logic           err_illegal,
  output logic           err_overflow,
  output logic [AW:0]    count
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [8:0]     checksum
`endif
);

  enc_state_t    state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   count_q, count_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [8:0]    mem_wdata_q, mem_wdata_d;
  logic          err_ill_q, err_ill_d;
  logic          err_ovf_q, err_ovf_d;
`ifdef ENC_CHECKSUM_EN
  logic [8:0]    csum_q, csum_d;
`endif

  logic [8:0] word;
  logic       illegal;
  logic       addr_full;
  logic       accept;

  instr_pack u_pack (
    .cls_i     (in_if.in_class),
    .op_i      (in_if.in_op),
    .a_i       (in_if.in_a),
    .b_i       (in_if.in_b),
    .imm_i     (in_if.in_imm),
    .word_o    (word),
    .illegal_o (illegal)
  );

  // The last address is reserved for the terminator, so stop accepting there.
  assign addr_full      = &waddr_q;
  assign in_if.in_ready = (state_q == LOAD) && !addr_full;
  assign accept         = in_if.in_ready && in_if.in_valid;

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_ill_d   = err_ill_q;
    err_ovf_d   = err_ovf_q;
`ifdef ENC_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (illegal) begin
            err_ill_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = waddr_q;
            mem_wdata_d = word;
            waddr_d     = waddr_q + AW'(1);
            count_d     = count_q + (AW+1)'(1);
`ifdef ENC_CHECKSUM_EN
            csum_d      = csum_q ^ word;
`endif
          end
          if (in_if.in_last) state_d = FLUSH;
        end else if (addr_full) begin
          err_ovf_d = 1'b1;
          state_d   = FLUSH;
        end
      end
      FLUSH: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = waddr_q;
        mem_wdata_d = HALT_WORD;
`ifdef ENC_CHECKSUM_EN
        csum_d      = csum_q ^ HALT_WORD;
`endif
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A restart overrides everything except a beat write accepted this cycle.
    if (load_start) begin
      state_d   = LOAD;
      waddr_d   = '0;
      count_d   = '0;
      err_ill_d = 1'b0;
      err_ovf_d = 1'b0;
`ifdef ENC_CHECKSUM_EN
      csum_d    = '0;
`endif
      if (state_q == FLUSH) mem_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_ill_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_ill_q   <= err_ill_d;
      err_ovf_q   <= err_ovf_d;
`ifdef ENC_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = (state_q == LOAD) || (state_q == FLUSH);
  assign done         = (state_q == DONE);
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;
  assign count        = count_q;
`ifdef ENC_CHECKSUM_EN
  assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a full-depth instance (AW=8) and a
// shallow instance (AW=2) for the overflow path.
module tb_instr_encoder;
  import x9_isa_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ls8   = 1'b0;
  logic ls2   = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if if8 ();
  instr_encoder_if if2 ();

  logic       we8, busy8, done8, ill8, ovf8;
  logic [7:0] addr8;
  logic [8:0] wdata8;
  logic [8:0] count8;
  logic       we2, busy2, done2, ill2, ovf2;
  logic [1:0] addr2;
  logic [8:0] wdata2;
  logic [2:0] count2;
`ifdef ENC_CHECKSUM_EN
  logic [8:0] csum8, csum2;
`endif

  instr_encoder #(.AW(8)) u8 (
    .clk(clk), .rst_n(rst_n), .load_start(ls8), .in_if(if8.slave),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8), .busy(busy8),
    .done(done8), .err_illegal(ill8), .err_overflow(ovf8), .count(count8)
`ifdef ENC_CHECKSUM_EN
    , .checksum(csum8)
`endif
  );

  instr_encoder #(.AW(2)) u2 (
    .clk(clk), .rst_n(rst_n), .load_start(ls2), .in_if(if2.slave),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .busy(busy2),
    .done(done2), .err_illegal(ill2), .err_overflow(ovf2), .count(count2)
`ifdef ENC_CHECKSUM_EN
    , .checksum(csum2)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int sel    = 8;
  logic [16:0] cap8[$];
  logic [16:0] cap2[$];
  logic [16:0] exp_q[$];

  // Capture every memory write as {addr, data}, away from the active edge.
  always @(negedge clk) begin
    if (we8) cap8.push_back({addr8, wdata8});
    if (we2) cap2.push_back({6'b0, addr2, wdata2});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    if (sel == 2) ls2 = 1'b1; else ls8 = 1'b1;
    @(posedge clk); #1;
    ls2 = 1'b0; ls8 = 1'b0;
  endtask

  task automatic set_fields(input logic [1:0] cls, input logic [4:0] op, input logic [3:0] a,
                            input logic [2:0] b, input logic [6:0] imm, input logic last);
    if8.in_class = cls; if8.in_op = op; if8.in_a = a; if8.in_b = b; if8.in_imm = imm; if8.in_last = last;
    if2.in_class = cls; if2.in_op = op; if2.in_a = a; if2.in_b = b; if2.in_imm = imm; if2.in_last = last;
  endtask

  // Present one beat until it is accepted (bounded); optional load_start in the accept cycle.
  task automatic send_beat(input logic [1:0] cls, input logic [4:0] op, input logic [3:0] a,
                           input logic [2:0] b, input logic [6:0] imm, input logic last,
                           input logic ls = 1'b0);
    bit acc = 1'b0;
    set_fields(cls, op, a, b, imm, last);
    if (sel == 2) if2.in_valid = 1'b1; else if8.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      if ((sel == 2) ? if2.in_ready : if8.in_ready) begin
        if (ls) begin if (sel == 2) ls2 = 1'b1; else ls8 = 1'b1; end
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    if8.in_valid = 1'b0; if2.in_valid = 1'b0; ls8 = 1'b0; ls2 = 1'b0;
    $display("beat dut=%0d cls=%0d op=%0d a=%0d b=%0d imm=0x%0h last=%0b start=%0b accepted=%0b",
             sel, cls, op, a, b, imm, last, ls, acc);
    check("beat_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((sel == 2) ? done2 : done8) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'((sel == 2) ? done2 : done8), 32'd0);
  endtask

  task automatic compare_writes(input string tag);
    logic [16:0] got[$];
    if (sel == 2) got = cap2; else got = cap8;
    check({tag, "_nwrites"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_write%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    if8.in_valid = 1'b0; if2.in_valid = 1'b0;
    set_fields(2'b00, 5'd0, 4'd0, 3'd0, 7'd0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(if8.in_ready), 32'd0);
    check("rst_we", 32'(we8), 32'd0);
    check("rst_busy_done", 32'({busy8, done8}), 32'd0);
    check("rst_errs", 32'({ill8, ovf8}), 32'd0);
    check("rst_addr_data", 32'({addr8, wdata8}), 32'd0);
    check("rst_count", 32'(count8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: basic three-instruction program
    sel = 8; cap8.delete();
    pulse_start();
    check("s1_busy", 32'(busy8), 32'd1);
    send_beat(CLS_R,    5'd2, 4'd5, 3'd0, 7'h00, 1'b0);
    send_beat(CLS_MOVI, 5'd0, 4'd0, 3'd0, 7'h7F, 1'b0);
    send_beat(CLS_MOVR, 5'd0, 4'd3, 3'd6, 7'h00, 1'b1);
    wait_done("s1_done");
    exp_q = '{{8'd0, 9'h025}, {8'd1, 9'h1FF}, {8'd2, 9'h11E}, {8'd3, 9'h1FF}};
    compare_writes("s1");
    check("s1_count", 32'(count8), 32'd3);
    check("s1_errs", 32'({ill8, ovf8}), 32'd0);
    check("s1_busy_after", 32'(busy8), 32'd0);
`ifdef ENC_CHECKSUM_EN
    check("s1_csum", 32'(csum8), 32'h13B);
`endif

    // Scenario 2: reserved class and opcode>15 mid-stream
    cap8.delete();
    pulse_start();
    send_beat(CLS_R,    5'd1,  4'd1, 3'd0, 7'h00, 1'b0);
    send_beat(CLS_RSVD, 5'd0,  4'd0, 3'd0, 7'h00, 1'b0);
    send_beat(CLS_R,    5'd16, 4'd0, 3'd0, 7'h00, 1'b0);
    send_beat(CLS_MOVI, 5'd0,  4'd0, 3'd0, 7'h05, 1'b1);
    wait_done("s2_done");
    exp_q = '{{8'd0, 9'h011}, {8'd1, 9'h185}, {8'd2, 9'h1FF}};
    compare_writes("s2");
    check("s2_count", 32'(count8), 32'd2);
    check("s2_err_illegal", 32'(ill8), 32'd1);
    check("s2_err_overflow", 32'(ovf8), 32'd0);

    // Scenario 3: AW=2 overflow without in_last
    sel = 2; cap2.delete();
    pulse_start();
    send_beat(CLS_R, 5'd0, 4'd1, 3'd0, 7'h00, 1'b0);
    send_beat(CLS_R, 5'd0, 4'd2, 3'd0, 7'h00, 1'b0);
    send_beat(CLS_R, 5'd0, 4'd3, 3'd0, 7'h00, 1'b0);
    check("s3_ready_low", 32'(if2.in_ready), 32'd0);
    set_fields(CLS_R, 5'd0, 4'd4, 3'd0, 7'h00, 1'b0);
    if2.in_valid = 1'b1;
    wait_done("s3_done");
    if2.in_valid = 1'b0;
    exp_q = '{{8'd0, 9'h001}, {8'd1, 9'h002}, {8'd2, 9'h003}, {8'd3, 9'h1FF}};
    compare_writes("s3");
    check("s3_err_overflow", 32'(ovf2), 32'd1);
    check("s3_err_illegal", 32'(ill2), 32'd0);
    check("s3_count", 32'(count2), 32'd3);
    check("s3_busy_after", 32'(busy2), 32'd0);
`ifdef ENC_CHECKSUM_EN
    check("s3_csum", 32'(csum2), 32'h1FF);
`endif

    // Scenario 4: throttled stream, restart coinciding with in_last acceptance
    sel = 8; cap8.delete();
    pulse_start();
    check("s4_flags_cleared", 32'({ill8, ovf8}), 32'd0);
    check("s4_count_cleared", 32'(count8), 32'd0);
    idle($urandom_range(0, 2));
    send_beat(CLS_MOVR, 5'd0, 4'd1, 3'd1, 7'h00, 1'b0);
    idle($urandom_range(0, 2));
    send_beat(CLS_R, 5'd3, 4'd3, 3'd0, 7'h00, 1'b1, 1'b1);
    check("s4_restart_busy", 32'(busy8), 32'd1);
    check("s4_restart_count", 32'(count8), 32'd0);
    idle($urandom_range(0, 2));
    send_beat(CLS_MOVI, 5'd0, 4'd0, 3'd0, 7'h11, 1'b0);
    idle($urandom_range(0, 2));
    send_beat(CLS_R, 5'd15, 4'd15, 3'd0, 7'h00, 1'b1);
    wait_done("s4_done");
    exp_q = '{{8'd0, 9'h109}, {8'd1, 9'h033}, {8'd0, 9'h191}, {8'd1, 9'h0FF}, {8'd2, 9'h1FF}};
    compare_writes("s4");
    check("s4_count", 32'(count8), 32'd2);
`ifdef ENC_CHECKSUM_EN
    check("s4_csum", 32'(csum8), 32'h091);
`endif

    // Scenario 5: reset during LOAD with a write pending
    cap8.delete();
    pulse_start();
    send_beat(CLS_R, 5'd2, 4'd5, 3'd0, 7'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("s5_we", 32'(we8), 32'd0);
    check("s5_busy", 32'(busy8), 32'd0);
    check("s5_addr_data", 32'({addr8, wdata8}), 32'd0);
    check("s5_ready", 32'(if8.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check("s5_no_writes", 32'(cap8.size()), 32'd0);
    check("s5_done", 32'(done8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
